// File: rtl/ace_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the Z80 and video fetch; video has priority.
// Optional CPU starvation guard: define ACE_ARB_STARVE_GUARD_EN.
module ace_vram_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 8,
    parameter int MAX_VID_RUN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_ack,
    input  logic          cpu_sel,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    dbg_state
);

    // Handshakes: vid_req is a level held until the one-cycle vid_ack (data valid with it);
    // the CPU strobe is stalled by cpu_wait_n low until its access completes (cpu_done).
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_CAPT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          owner_cpu_q, owner_cpu_d;
    logic          op_wr_q, op_wr_d;
    logic          abort_q, abort_d;
    logic          cpu_done_q, cpu_done_d;
    logic          vid_ack_q, vid_ack_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;

    logic cpu_req, cpu_busy, cpu_pend, arb_point, guard_hit, cpu_grant, vid_grant;

    assign cpu_req    = cpu_sel & (cpu_rd | cpu_wr) & ~cpu_done_q;
    assign cpu_wait_n = ~cpu_req;
    // The CPU access already in flight must not be granted a second time at its own CAPT edge.
    assign cpu_busy   = owner_cpu_q & ~abort_q & (state_q != ST_IDLE);
    assign cpu_pend   = cpu_req & ~cpu_busy;
    assign arb_point  = (state_q == ST_IDLE) || (state_q == ST_CAPT);
    assign cpu_grant  = arb_point & cpu_pend & (~vid_req | guard_hit);
    assign vid_grant  = arb_point & vid_req & ~cpu_grant;

`ifdef ACE_ARB_STARVE_GUARD_EN
    localparam int RW = $clog2(MAX_VID_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_VID_RUN);

    logic [RW-1:0] run_q, run_d;

    assign guard_hit = cpu_pend && (run_q == RUN_MAX);

    always_comb begin
        run_d = run_q;
        if (!cpu_pend || cpu_grant) run_d = '0;
        else if (vid_grant) run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_q <= '0;
        else        run_q <= run_d;
    end
`else
    assign guard_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        op_wr_d     = op_wr_q;
        abort_d     = abort_q;
        cpu_done_d  = cpu_done_q;
        vid_ack_d   = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        vid_data_d  = vid_data_q;
        cpu_dout_d  = cpu_dout_q;

        if (!cpu_sel) cpu_done_d = 1'b0;
        if (cpu_busy && !cpu_sel) abort_d = 1'b1;

        case (state_q)
            ST_ISSUE: state_d = ST_CAPT;
            ST_CAPT: begin
                if (!owner_cpu_q) begin
                    vid_data_d = ram_dout;
                    vid_ack_d  = 1'b1;
                end else begin
                    if (!op_wr_q) cpu_dout_d = ram_dout;
                    // An aborted bus cycle still finishes at the RAM but never reports done.
                    if (cpu_sel && !abort_q) cpu_done_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (arb_point) begin
            state_d = ST_IDLE;
            if (cpu_grant) begin
                state_d     = ST_ISSUE;
                owner_cpu_d = 1'b1;
                op_wr_d     = cpu_wr;
                abort_d     = 1'b0;
                ram_addr_d  = cpu_addr;
                ram_din_d   = cpu_din;
                ram_we_d    = cpu_wr;
            end else if (vid_grant) begin
                state_d     = ST_ISSUE;
                owner_cpu_d = 1'b0;
                ram_addr_d  = vid_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_cpu_q <= 1'b0;
            op_wr_q     <= 1'b0;
            abort_q     <= 1'b0;
            cpu_done_q  <= 1'b0;
            vid_ack_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            vid_data_q  <= '0;
            cpu_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            op_wr_q     <= op_wr_d;
            abort_q     <= abort_d;
            cpu_done_q  <= cpu_done_d;
            vid_ack_q   <= vid_ack_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            vid_data_q  <= vid_data_d;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_dout  = cpu_dout_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign dbg_state = state_q;

endmodule
